// File: rtl/fifo_cmd_writer_pkg.sv
// Shared constants for the host-side display-command FIFO writer:
// reset/full-flag polarities, write-cycle state encoding and a tick helper.
package fifo_cmd_writer_pkg;

  localparam logic RESET_ASSERTED = 1'b0;
  localparam logic FIFO_FULL      = 1'b0;
  localparam logic FIFO_NOT_FULL  = 1'b1;

  localparam logic [2:0] WR_IDLE    = 3'd0;
  localparam logic [2:0] WR_SETUP   = 3'd1;
  localparam logic [2:0] WR_STROBE  = 3'd2;
  localparam logic [2:0] WR_HOLD    = 3'd3;
  localparam logic [2:0] WR_RECOVER = 3'd4;

  // Terminal value of the per-state tick counter for a phase lasting `ticks` cycles.
  function automatic logic [7:0] last_tick(input int ticks);
    return 8'(ticks - 1);
  endfunction

endpackage

// File: rtl/fifo_cmd_writer_if.sv
// Host command handshake plus external FIFO write bus, grouped for the writer.
interface fifo_cmd_writer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        nff_in;
  logic [7:0]  fifo_data;
  logic        fifo_nwr;
  logic        busy;
  logic [15:0] wr_count;

  modport master (
    output in_data, in_valid, nff_in,
    input  in_ready, fifo_data, fifo_nwr, busy, wr_count
  );

  modport slave (
    input  in_data, in_valid, nff_in,
    output in_ready, fifo_data, fifo_nwr, busy, wr_count
  );
endinterface

// File: rtl/fifo_cmd_writer_byte_queue.sv
// Small first-word-fall-through byte queue with registered empty/full flags,
// reusable for other host-side buffering.
module fifo_cmd_writer_byte_queue
  import fifo_cmd_writer_pkg::*;
#(
  parameter int QDEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);

  localparam int DEPTH = 2 ** QDEPTH_LOG2;
  localparam logic [QDEPTH_LOG2-1:0] PTR_ONE   = QDEPTH_LOG2'(1);
  localparam logic [QDEPTH_LOG2:0]   CNT_ONE   = (QDEPTH_LOG2 + 1)'(1);
  localparam logic [QDEPTH_LOG2:0]   CNT_ZERO  = (QDEPTH_LOG2 + 1)'(0);
  localparam logic [QDEPTH_LOG2:0]   DEPTH_CNT = (QDEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]             r_mem [DEPTH];
  logic [QDEPTH_LOG2-1:0] r_wr_ptr;
  logic [QDEPTH_LOG2-1:0] r_rd_ptr;
  logic [QDEPTH_LOG2:0]   r_count;
  logic [QDEPTH_LOG2:0]   w_count_next;
  logic                   r_empty;
  logic                   r_full;
  logic                   w_do_push;
  logic                   w_do_pop;

  // A push at full is accepted only when the same cycle frees a slot.
  always_comb begin
    w_do_pop     = pop && !r_empty;
    w_do_push    = push && (!r_full || w_do_pop);
    w_count_next = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_next = r_count + CNT_ONE;
    end else if (!w_do_push && w_do_pop) begin
      w_count_next = r_count - CNT_ONE;
    end else begin
      w_count_next = r_count;
    end
  end

  // Pointers, occupancy and flags; full reads high in reset so nothing is accepted then.
  always_ff @(posedge clk) begin
    if (nrst == RESET_ASSERTED) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= CNT_ZERO;
      r_empty  <= 1'b1;
      r_full   <= 1'b1;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count <= w_count_next;
      r_empty <= (w_count_next == CNT_ZERO);
      r_full  <= (w_count_next == DEPTH_CNT);
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign empty = r_empty;
  assign full  = r_full;

endmodule

// File: rtl/fifo_cmd_writer.sv
// Host-side write port for the external 8-bit async display-command FIFO:
// queues host bytes and runs a tick-timed setup / -WR pulse / hold / recovery cycle.
module fifo_cmd_writer
  import fifo_cmd_writer_pkg::*;
#(
  parameter int SETUP_TICKS   = 2,
  parameter int PULSE_TICKS   = 4,
  parameter int HOLD_TICKS    = 1,
  parameter int RECOVER_TICKS = 2,
  parameter int QDEPTH_LOG2   = 2
) (
  input  logic              clk,
  input  logic              nrst,
  fifo_cmd_writer_if.slave  bus
);

  logic        r_nff;
  logic [2:0]  r_state;
  logic [7:0]  r_tick;
  logic [7:0]  r_data;
  logic        r_nwr;
  logic [15:0] r_wr_count;
  logic [7:0]  w_head;
  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;

  assign w_push = bus.in_valid && !w_full;
  assign w_pop  = (r_state == WR_IDLE) && !w_empty && (r_nff == FIFO_NOT_FULL);

  fifo_cmd_writer_byte_queue #(
    .QDEPTH_LOG2 (QDEPTH_LOG2)
  ) u_queue (
    .clk       (clk),
    .nrst      (nrst),
    .push      (w_push),
    .push_data (bus.in_data),
    .pop       (w_pop),
    .head      (w_head),
    .empty     (w_empty),
    .full      (w_full)
  );

  // Full flag is asynchronous to clk; every decision uses this registered copy.
  always_ff @(posedge clk) begin
    if (nrst == RESET_ASSERTED) begin
      r_nff <= FIFO_FULL;
    end else begin
      r_nff <= bus.nff_in;
    end
  end

  // Write-cycle sequencer; the tick counter restarts at zero on every state entry.
  always_ff @(posedge clk) begin
    if (nrst == RESET_ASSERTED) begin
      r_state    <= WR_IDLE;
      r_tick     <= 8'd0;
      r_data     <= 8'd0;
      r_nwr      <= 1'b1;
      r_wr_count <= 16'd0;
    end else begin
      case (r_state)
        WR_IDLE: begin
          r_nwr <= 1'b1;
          if (w_pop) begin
            r_data  <= w_head;
            r_state <= WR_SETUP;
            r_tick  <= 8'd0;
          end
        end
        WR_SETUP: begin
          if (r_tick == last_tick(SETUP_TICKS)) begin
            r_nwr   <= 1'b0;
            r_state <= WR_STROBE;
            r_tick  <= 8'd0;
          end else begin
            r_tick <= r_tick + 8'd1;
          end
        end
        WR_STROBE: begin
          // The write completes even if the full flag drops mid-pulse; the FIFO drops it.
          if (r_tick == last_tick(PULSE_TICKS)) begin
            r_nwr      <= 1'b1;
            r_wr_count <= r_wr_count + 16'd1;
            r_state    <= WR_HOLD;
            r_tick     <= 8'd0;
          end else begin
            r_tick <= r_tick + 8'd1;
          end
        end
        WR_HOLD: begin
          if (r_tick == last_tick(HOLD_TICKS)) begin
            r_state <= WR_RECOVER;
            r_tick  <= 8'd0;
          end else begin
            r_tick <= r_tick + 8'd1;
          end
        end
        WR_RECOVER: begin
          if (r_tick == last_tick(RECOVER_TICKS)) begin
            r_state <= WR_IDLE;
            r_tick  <= 8'd0;
          end else begin
            r_tick <= r_tick + 8'd1;
          end
        end
        default: begin
          r_state <= WR_IDLE;
          r_tick  <= 8'd0;
          r_nwr   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = !w_full;
  assign bus.fifo_data = r_data;
  assign bus.fifo_nwr  = r_nwr;
  assign bus.busy      = (r_state != WR_IDLE) || !w_empty;
  assign bus.wr_count  = r_wr_count;

endmodule

// File: tb/tb_fifo_cmd_writer.sv
// Self-checking bench for fifo_cmd_writer: scoreboard of expected FIFO bytes,
// strobe timing, full-flag stalls, reset mid-write and counter/pointer wrap.
module tb_fifo_cmd_writer;

  localparam int SETUP_T = 2;
  localparam int PULSE_T = 4;
  localparam int CYCLE_T = 10;

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  fifo_cmd_writer_if bus ();

  fifo_cmd_writer dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial forever #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  int         n_falls = 0;
  logic [7:0] exp_q[$];
  int         fall_q[$];
  logic       ignore_width = 1'b0;

  // Watches the -WR strobe: pops the scoreboard on each falling edge, checks width.
  task automatic monitor();
    logic       prev_nwr = 1'b1;
    int         low_len  = 0;
    logic [7:0] pulse_data = 8'h00;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.fifo_nwr === 1'b0 && prev_nwr === 1'b1) begin
        n_falls++;
        fall_q.push_back(cyc);
        low_len    = 1;
        pulse_data = bus.fifo_data;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL spurious_strobe: wrote %02h with no byte expected", bus.fifo_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (bus.fifo_data !== exp_b) begin
            n_bad++;
            $display("FAIL write_data: got %02h want %02h", bus.fifo_data, exp_b);
          end
        end
      end else if (bus.fifo_nwr === 1'b0) begin
        low_len++;
        n_cmp++;
        if (bus.fifo_data !== pulse_data) begin
          n_bad++;
          $display("FAIL data_stable: got %02h want %02h", bus.fifo_data, pulse_data);
        end
      end else if (prev_nwr === 1'b0 && !ignore_width) begin
        n_cmp++;
        if (low_len != PULSE_T) begin
          n_bad++;
          $display("FAIL pulse_width: got %0d want %0d", low_len, PULSE_T);
        end
      end
      prev_nwr = bus.fifo_nwr;
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL push_timeout: in_ready %b want 1", bus.in_ready);
    end else begin
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      exp_q.push_back(b);
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy !== 1'b0 || bus.fifo_nwr !== 1'b1) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: busy %b want 0", bus.busy);
    end
  endtask

  task automatic wait_strobe();
    int n = 0;
    while (bus.fifo_nwr !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL strobe_timeout: nwr %b want 0", bus.fifo_nwr);
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.nff_in = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.fifo_nwr !== 1'b1) begin n_bad++; $display("FAIL reset_nwr: got %b want 1", bus.fifo_nwr); end
    n_cmp++; if (bus.fifo_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %02h want 00", bus.fifo_data); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.wr_count !== 16'h0000) begin n_bad++; $display("FAIL reset_count: got %04h want 0000", bus.wr_count); end
    nrst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single();
    logic exp_nwr;
    push_byte(8'hA5);
    // k counts edges from acceptance (edge 1); SETUP entered at edge 2
    for (int k = 2; k <= 11; k++) begin
      @(negedge clk);
      exp_nwr = (k >= 2 + SETUP_T && k < 2 + SETUP_T + PULSE_T) ? 1'b0 : 1'b1;
      n_cmp++; if (bus.fifo_nwr !== exp_nwr) begin n_bad++; $display("FAIL single_nwr k=%0d: got %b want %b", k, bus.fifo_nwr, exp_nwr); end
      n_cmp++; if (bus.busy !== (k <= 10)) begin n_bad++; $display("FAIL single_busy k=%0d: got %b want %b", k, bus.busy, (k <= 10)); end
      if (k == 2) begin
        n_cmp++; if (bus.fifo_data !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %02h want a5", bus.fifo_data); end
      end
      if (k == 7 || k == 8) begin
        n_cmp++; if (bus.wr_count !== ((k == 8) ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL single_count k=%0d: got %0d", k, bus.wr_count); end
      end
    end
  endtask

  task automatic test_burst();
    logic [15:0] cnt0;
    cnt0 = bus.wr_count;
    fall_q.delete();
    for (int i = 1; i <= 6; i++) begin
      push_byte(8'(i));
      if (i == 5) begin
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL burst_ready: got %b want 0", bus.in_ready); end
      end
    end
    wait_idle();
    n_cmp++; if (bus.wr_count !== cnt0 + 16'd6) begin n_bad++; $display("FAIL burst_count: got %0d want %0d", bus.wr_count, cnt0 + 16'd6); end
    n_cmp++; if (fall_q.size() != 6) begin n_bad++; $display("FAIL burst_strobes: got %0d want 6", fall_q.size()); end
    for (int i = 1; i < fall_q.size(); i++) begin
      n_cmp++; if (fall_q[i] - fall_q[i-1] != CYCLE_T) begin n_bad++; $display("FAIL burst_spacing: got %0d want %0d", fall_q[i] - fall_q[i-1], CYCLE_T); end
    end
  endtask

  task automatic test_full_stall();
    int f0;
    int stuck = 0;
    bus.nff_in = 1'b0;
    repeat (2) @(negedge clk);
    push_byte(8'h11);
    push_byte(8'h22);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.fifo_nwr !== 1'b1) stuck++;
    end
    n_cmp++; if (stuck != 0) begin n_bad++; $display("FAIL stall_nwr: low %0d cycles want 0", stuck); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL stall_busy: got %b want 1", bus.busy); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_ready: got %b want 1", bus.in_ready); end
    f0 = n_falls;
    bus.nff_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++; if (bus.fifo_nwr !== ((k == 4) ? 1'b0 : 1'b1)) begin n_bad++; $display("FAIL release_nwr k=%0d: got %b", k, bus.fifo_nwr); end
    end
    wait_idle();
    n_cmp++; if (n_falls - f0 != 2) begin n_bad++; $display("FAIL release_strobes: got %0d want 2", n_falls - f0); end
  endtask

  task automatic test_full_mid_pulse();
    int f0;
    f0 = n_falls;
    push_byte(8'h33);
    push_byte(8'h44);
    wait_strobe();
    bus.nff_in = 1'b0;
    repeat (30) @(negedge clk);
    n_cmp++; if (n_falls - f0 != 1) begin n_bad++; $display("FAIL midpulse_strobes: got %0d want 1", n_falls - f0); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL midpulse_busy: got %b want 1", bus.busy); end
    n_cmp++; if (bus.fifo_nwr !== 1'b1) begin n_bad++; $display("FAIL midpulse_nwr: got %b want 1", bus.fifo_nwr); end
    bus.nff_in = 1'b1;
    wait_idle();
    n_cmp++; if (n_falls - f0 != 2) begin n_bad++; $display("FAIL midpulse_resume: got %0d want 2", n_falls - f0); end
  endtask

  task automatic test_wrap();
    int f0;
    wait_idle();
    force dut.r_wr_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_wr_count;
    @(negedge clk);
    n_cmp++; if (bus.wr_count !== 16'hFFFF) begin n_bad++; $display("FAIL preload_count: got %04h want ffff", bus.wr_count); end
    push_byte(8'h99);
    wait_idle();
    n_cmp++; if (bus.wr_count !== 16'h0000) begin n_bad++; $display("FAIL wrap_count: got %04h want 0000", bus.wr_count); end
    // Fill while stalled, then stream so the pointers lap several times at full
    f0 = n_falls;
    bus.nff_in = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i));
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL wrap_full_ready: got %b want 0", bus.in_ready); end
    bus.nff_in = 1'b1;
    for (int i = 4; i < 20; i++) push_byte(8'hC0 + 8'(i));
    wait_idle();
    n_cmp++; if (n_falls - f0 != 20) begin n_bad++; $display("FAIL wrap_strobes: got %0d want 20", n_falls - f0); end
    n_cmp++; if (bus.wr_count !== 16'd20) begin n_bad++; $display("FAIL wrap_total: got %0d want 20", bus.wr_count); end
  endtask

  task automatic test_reset_mid_write();
    int f0;
    push_byte(8'h55);
    push_byte(8'h66);
    push_byte(8'h77);
    wait_strobe();
    ignore_width = 1'b1;
    nrst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.fifo_nwr !== 1'b1) begin n_bad++; $display("FAIL rst_mid_nwr: got %b want 1", bus.fifo_nwr); end
    n_cmp++; if (bus.fifo_data !== 8'h00) begin n_bad++; $display("FAIL rst_mid_data: got %02h want 00", bus.fifo_data); end
    n_cmp++; if (bus.wr_count !== 16'h0000) begin n_bad++; $display("FAIL rst_mid_count: got %04h want 0000", bus.wr_count); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
    exp_q.delete();
    nrst = 1'b1;
    f0 = n_falls;
    repeat (30) @(negedge clk);
    ignore_width = 1'b0;
    n_cmp++; if (n_falls != f0) begin n_bad++; $display("FAIL rst_spurious: got %0d strobes want 0", n_falls - f0); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_after_busy: got %b want 0", bus.busy); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.nff_in   = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_burst();
    test_full_stall();
    test_full_mid_pulse();
    test_wrap();
    test_reset_mid_write();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL leftover_bytes: got %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
